lfsr_engine: RTL and testbench
==============================

# lfsr_engine

Parametrised WIDTH-bit Fibonacci LFSR with synchronous seed load, step enable, all-ones lock-up recovery, period tracking and a threshold comparator. It is the next generation of the team's single-bit LFSR register cell: that cell is now instantiated WIDTH times inside this engine, and the engine supplies the feedback network and control around it. It sits between the lab's clock-enable divider and game logic, such as the computer player, that needs a pseudo-random value or a "fire" decision against a switch-set threshold.

## Interface
- WIDTH, 10, register width in bits; legal range 3..16.
- TAPS, 10'b10_0100_0000, feedback mask; bit i set means Q[i] feeds the XNOR. The default is x^10+x^7+1.
- Clock  input  1  system clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high; clock Clock.
- Enable  input  1  advance one step on this edge.
- Load  input  1  replace state with LoadValue on this edge.
- LoadValue  input  WIDTH  seed for Load.
- Threshold  input  WIDTH  comparator reference.
- Q  output  WIDTH  current LFSR state.
- Bit  output  1  serial output, equal to Q[WIDTH-1].
- Fire  output  1  Q > Threshold, unsigned.
- StepCount  output  WIDTH  steps taken since the last start point.
- Wrap  output  1  one-cycle pulse when the sequence returns to its start state.
- Lockup  output  1  one-cycle pulse when all-ones recovery occurs.

## Operation
- Feedback: fb = ~^(Q & TAPS). This XNOR form makes all-zeros a legal state and all-ones the single lock-up state.
- Step: Q <= {Q[WIDTH-2:0], fb}.
- Control priority per edge is Reset > Load > Enable > hold.
- Reset: Q=0, StartState=0, StepCount=0, Wrap=0, Lockup=0.
- Load:
  - Q=LoadValue, StartState=LoadValue, StepCount=0, Wrap=0, Lockup=0.
  - Load with Enable asserted takes no step.
  - Loading all-ones is allowed; recovery occurs on the next Enable.
- Enable, with Q all-ones:
  - Q=0, StartState=0, StepCount=0, Lockup=1, Wrap=0.
- Enable, normal step:
  - If the next Q equals StartState, then Wrap=1 and StepCount=0.
  - Otherwise StepCount increments by 1, wraps modulo 2^WIDTH, and Wrap=0.
- Hold (no Reset, Load or Enable): Q, StepCount and StartState are unchanged. Wrap=0 and Lockup=0.
- Fire and Bit are combinational from Q and Threshold. Fire=0 when Q==Threshold.
- For a maximal-length TAPS, Wrap fires every 2^WIDTH-1 enabled steps. StepCount then peaks at 2^WIDTH-2, so it never overflows.

## Timing
- Registered outputs, all updated on the same edge: Q, StepCount, Wrap, Lockup, plus the internal StartState.
- Reset values of all outputs:
  - Q=0, StepCount=0, Wrap=0, Lockup=0.
  - Bit=0.
  - Fire=(0 > Threshold), which is 0.
- Latency: one edge from Enable or Load to the new Q. Wrap and Lockup are high for exactly the cycle after the causing edge.
- Enable held continuously gives one step per cycle; no bubbles.
- Reset mid-sequence takes effect on that edge regardless of Load or Enable. The start point returns to 0.
- Threshold changes affect Fire combinationally in the same cycle.

## Structure
- Package lfsr_pkg holds:
  - The default tap constants TAPS_4=4'b1100, TAPS_8=8'b1011_1000, TAPS_10=10'b10_0100_0000 and TAPS_16=16'hB400.
  - A function all_ones(width) used for lock-up detection.
- Sub-module lfsr_cell: a one-bit register with synchronous reset and a mux-free D input. The engine instantiates it WIDTH times in a generate loop. The engine's control logic computes each cell's D from reset/load/shift/hold.
- Top-level logic contains the feedback reduction, the StartState register, the StepCount counter and the comparator.

## Test plan
- WIDTH=4, TAPS=4'b1100, Reset then 4 Enable cycles -> Q goes 0001, 0011, 0111, 1110; StepCount is 4; Bit=1 after the 4th step.
- Same configuration, 15 continuous Enable cycles from reset -> Q returns to 0000 and Wrap=1 for exactly one cycle with StepCount=0. The 16th step gives Q=0001 and Wrap=0.
- Load=1 with LoadValue=4'b1111 and Enable=1 on the same edge -> Q=1111 with no step. Next Enable edge -> Q=0000, Lockup=1 for one cycle.
- Load with LoadValue=4'b0110, then Enable for 15 steps -> Wrap pulses when Q returns to 0110, and not at 0000.
- Threshold=4'b0110 while stepping from reset -> Fire=0 at Q=0001 and 0011, Fire=1 at 0111 and 1110. Setting Threshold=4'b1110 at Q=1110 -> Fire=0 in the same cycle.
- Reset asserted mid-sequence at Q=1101 with Load=1 and Enable=1 -> next cycle Q=0000 and StepCount=0. A later 15-step run wraps at 0000.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared tap constants and helpers for the LFSR engine
package lfsr_pkg;
  localparam logic [3:0]  TAPS_4  = 4'b1100;
  localparam logic [7:0]  TAPS_8  = 8'b1011_1000;
  localparam logic [9:0]  TAPS_10 = 10'b10_0100_0000;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  function automatic logic [15:0] all_ones(input int width);
    return 16'((32'd1 << width) - 32'd1);
  endfunction
endpackage

// File: rtl/lfsr_engine_if.sv
// lfsr_engine_if: control inputs and state outputs of the LFSR engine
interface lfsr_engine_if #(parameter int WIDTH = 10);
  logic             Enable;
  logic             Load;
  logic [WIDTH-1:0] LoadValue;
  logic [WIDTH-1:0] Threshold;
  logic [WIDTH-1:0] Q;
  logic             Bit;
  logic             Fire;
  logic [WIDTH-1:0] StepCount;
  logic             Wrap;
  logic             Lockup;
  modport master (output Enable, Load, LoadValue, Threshold, input Q, Bit, Fire, StepCount, Wrap, Lockup);
  modport slave (input Enable, Load, LoadValue, Threshold, output Q, Bit, Fire, StepCount, Wrap, Lockup);
endinterface

// File: rtl/lfsr_cell.sv
// lfsr_cell: one-bit register with synchronous reset; D is computed by the engine
module lfsr_cell (
  input  logic Clock,
  input  logic Reset,
  input  logic d,
  output logic q
);
  always_ff @(posedge Clock) q <= Reset ? 1'b0 : d;
endmodule

// File: rtl/lfsr_engine.sv
// lfsr_engine: XNOR Fibonacci LFSR with seed load, lock-up recovery, period tracking and threshold compare
module lfsr_engine
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_10
) (
  input logic          Clock,
  input logic          Reset,
  lfsr_engine_if.slave bus
);
  logic [WIDTH-1:0] q, d, step_q, start, count;
  logic             fb, lock, wrap, lockup;
  assign fb     = ~^(q & TAPS);
  assign step_q = {q[WIDTH-2:0], fb};
  assign lock   = q == WIDTH'(all_ones(WIDTH));
  // all-ones is the only state XNOR feedback cannot leave, so an enabled step forces zero
  assign d = bus.Load ? bus.LoadValue : bus.Enable ? (lock ? '0 : step_q) : q;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    lfsr_cell u_cell (.Clock(Clock), .Reset(Reset), .d(d[i]), .q(q[i]));
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      start  <= '0;
      count  <= '0;
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end else begin
      wrap   <= 1'b0;
      lockup <= 1'b0;
      if (bus.Load) begin
        start <= bus.LoadValue;
        count <= '0;
      end else if (bus.Enable && lock) begin
        start  <= '0;
        count  <= '0;
        lockup <= 1'b1;
      end else if (bus.Enable && step_q == start) begin
        count <= '0;
        wrap  <= 1'b1;
      end else if (bus.Enable) begin
        count <= count + 1'b1;
      end
    end
  end
  assign bus.Q         = q;
  assign bus.Bit       = q[WIDTH-1];
  assign bus.Fire      = q > bus.Threshold;
  assign bus.StepCount = count;
  assign bus.Wrap      = wrap;
  assign bus.Lockup    = lockup;
endmodule

// File: tb/tb_lfsr_engine.sv
// tb_lfsr_engine: directed plan cases plus randomized control against an arithmetic reference model
module tb_lfsr_engine;
  localparam int W = 4;
  localparam logic [3:0] T = 4'b1100;
  logic Clock = 1'b0;
  logic Reset;
  lfsr_engine_if #(.WIDTH(W)) bus ();
  lfsr_engine #(.WIDTH(W), .TAPS(T)) dut (.Clock(Clock), .Reset(Reset), .bus(bus.slave));
  always #5 Clock = ~Clock;
  int checks = 0, errors = 0;
  int mq = 0, ms = 0, mc = 0, mw = 0, ml = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  // reference: state as an integer, next = 2*q + (even parity of tapped bits) mod 16
  task automatic model(input bit r, input bit l, input bit e, input int lv);
    mw = 0;
    ml = 0;
    if (r) begin
      mq = 0; ms = 0; mc = 0;
    end else if (l) begin
      mq = lv; ms = lv; mc = 0;
    end else if (e) begin
      if (mq == 15) begin
        mq = 0; ms = 0; mc = 0; ml = 1;
      end else begin
        mq = (mq * 2 + ((($countones(mq & int'(T))) % 2) == 0 ? 1 : 0)) % 16;
        if (mq == ms) begin
          mw = 1; mc = 0;
        end else mc = (mc + 1) % 16;
      end
    end
  endtask
  task automatic compare_all(input int th);
    check("Q", 32'(bus.Q), mq);
    check("Bit", 32'(bus.Bit), mq / 8);
    check("Fire", 32'(bus.Fire), (mq > th) ? 1 : 0);
    check("StepCount", 32'(bus.StepCount), mc);
    check("Wrap", 32'(bus.Wrap), mw);
    check("Lockup", 32'(bus.Lockup), ml);
  endtask
  task automatic cyc(input bit r, input bit l, input bit e, input int lv, input int th);
    Reset = r;
    bus.Load = l;
    bus.Enable = e;
    bus.LoadValue = 4'(lv);
    bus.Threshold = 4'(th);
    @(posedge Clock);
    model(r, l, e, lv);
    #1 compare_all(th);
  endtask
  initial begin
    int exp_seq[4] = '{1, 3, 7, 14};
    int n;
    Reset = 1'b1;
    bus.Load = 1'b0;
    bus.Enable = 1'b0;
    bus.LoadValue = '0;
    bus.Threshold = '0;
    cyc(1, 0, 0, 0, 6);
    check("reset_q", 32'(bus.Q), 0);
    check("reset_fire", 32'(bus.Fire), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0, 6);
      check("plan_seq", 32'(bus.Q), exp_seq[i]);
      check("plan_fire", 32'(bus.Fire), i >= 2 ? 1 : 0);
    end
    check("plan_count4", 32'(bus.StepCount), 4);
    check("plan_bit", 32'(bus.Bit), 1);
    bus.Threshold = 4'b1110;
    #1 check("fire_equal", 32'(bus.Fire), 0);
    for (int i = 4; i < 15; i++) cyc(0, 0, 1, 0, 14);
    check("wrap_q", 32'(bus.Q), 0);
    check("wrap_pulse", 32'(bus.Wrap), 1);
    check("wrap_count", 32'(bus.StepCount), 0);
    cyc(0, 0, 1, 0, 14);
    check("step16_q", 32'(bus.Q), 1);
    check("step16_wrap", 32'(bus.Wrap), 0);
    cyc(0, 1, 1, 15, 0);
    check("load_ones_q", 32'(bus.Q), 15);
    cyc(0, 0, 1, 0, 0);
    check("lock_q", 32'(bus.Q), 0);
    check("lock_pulse", 32'(bus.Lockup), 1);
    cyc(0, 0, 0, 0, 0);
    check("lock_clear", 32'(bus.Lockup), 0);
    cyc(0, 1, 0, 6, 0);
    for (int i = 0; i < 15; i++) begin
      cyc(0, 0, 1, 0, 0);
      check("seed_wrap", 32'(bus.Wrap), i == 14 ? 1 : 0);
    end
    check("seed_back", 32'(bus.Q), 6);
    cyc(1, 0, 0, 0, 0);
    n = 0;
    while (bus.Q != 4'b1101 && n < 20) begin
      cyc(0, 0, 1, 0, 0);
      n++;
    end
    check("reach_1101", 32'(bus.Q), 13);
    cyc(1, 1, 1, 5, 0);
    check("midreset_q", 32'(bus.Q), 0);
    check("midreset_count", 32'(bus.StepCount), 0);
    for (int i = 0; i < 15; i++) begin
      cyc(0, 0, 1, 0, 0);
      check("midreset_wrap", 32'(bus.Wrap), i == 14 ? 1 : 0);
    end
    for (int i = 0; i < 800; i++) begin
      int lv;
      lv = ($urandom_range(0, 3) == 0) ? 15 : int'($urandom_range(0, 15));
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 75, lv, int'($urandom_range(0, 15)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
